// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and parity types.
// The RX-side checkers import the same constants.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // data_xor is the XOR-reduction of the data word; odd type inverts it
   function automatic logic parity_bit(input logic data_xor, input logic par_typ);
      return data_xor ^ par_typ;
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Holds the latched data word and the bit index for the UART transmitter.
// ser_bit presents the bit that will be on the line after the coming edge.
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  load,
   input  logic                  shift_en,
   input  logic [DATA_WIDTH-1:0] p_data,
   output logic                  ser_bit,
   output logic                  ser_done,
   output logic [DATA_WIDTH-1:0] lat_data
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] data_d, data_q;
   logic [CNT_W-1:0]      cnt_d, cnt_q;

   // Next data word and bit index; index restarts on every load and stops at the last bit
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (load) begin
         data_d = p_data;
         cnt_d  = {CNT_W{1'b0}};
      end else if (shift_en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Data and index registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         data_q <= {DATA_WIDTH{1'b0}};
         cnt_q  <= {CNT_W{1'b0}};
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign ser_bit  = data_q[cnt_d];
   assign ser_done = (cnt_q == LAST_IDX);
   assign lat_data = data_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit,
// one bit per CLK. TX_OUT and BUSY are registered and reflect the state just entered.
module uart_tx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  BUSY
);

   import uart_pkg::*;

   uart_state_e           state_d, state_q;
   logic                  par_en_d, par_en_q;
   logic                  par_typ_d, par_typ_q;
   logic                  tx_d, tx_q;
   logic                  busy_d, busy_q;
   logic                  load_s, shift_en_s, ser_bit_s, ser_done_s;
   logic [DATA_WIDTH-1:0] lat_data_s;

   uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
      .CLK      (CLK),
      .RST      (RST),
      .load     (load_s),
      .shift_en (shift_en_s),
      .p_data   (P_DATA),
      .ser_bit  (ser_bit_s),
      .ser_done (ser_done_s),
      .lat_data (lat_data_s)
   );

   // Next state plus the line level and BUSY that belong to that next state
   always_comb begin
      state_d    = state_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      tx_d       = IDLE_LEVEL;
      busy_d     = 1'b0;
      load_s     = 1'b0;
      shift_en_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (DATA_VALID) begin
               load_s    = 1'b1;
               par_en_d  = PAR_EN;
               par_typ_d = PAR_TYP;
               state_d   = START;
               tx_d      = START_BIT;
               busy_d    = 1'b1;
            end else begin
               state_d = IDLE;
               tx_d    = IDLE_LEVEL;
               busy_d  = 1'b0;
            end
         end
         START: begin
            state_d = DATA;
            tx_d    = ser_bit_s;
            busy_d  = 1'b1;
         end
         DATA: begin
            busy_d = 1'b1;
            if (!ser_done_s) begin
               shift_en_s = 1'b1;
               tx_d       = ser_bit_s;
            end else if (par_en_q) begin
               state_d = PARITY;
               tx_d    = parity_bit(^lat_data_s, par_typ_q);
            end else begin
               state_d = STOP;
               tx_d    = STOP_BIT;
            end
         end
         PARITY: begin
            state_d = STOP;
            tx_d    = STOP_BIT;
            busy_d  = 1'b1;
         end
         STOP: begin
            state_d = IDLE;
            tx_d    = IDLE_LEVEL;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            tx_d    = IDLE_LEVEL;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, sampled frame options and registered outputs; reset drops the line to idle at once
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         tx_q      <= IDLE_LEVEL;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign TX_OUT = tx_q;
   assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level queue model checked every cycle, directed
// scenarios with literal expectations, and a randomized strobe/data phase.
module tb_uart_tx;

   logic       CLK;
   logic       RST;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       TX_OUT;
   logic       BUSY;

   int total;
   int bad;
   logic check_en;

   uart_tx #(.DATA_WIDTH(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .TX_OUT     (TX_OUT),
      .BUSY       (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Model: queue of {tx, busy} values for the cycles still to come in the current frame
   logic [1:0] exp_q[$];
   logic       cur_tx;
   logic       cur_busy;

   function automatic void push_rest_of_frame(input logic [7:0] d, input logic pe, input logic pt);
      int ones;
      ones = $countones(d);
      for (int i = 0; i < 8; i++) exp_q.push_back({d[i], 1'b1});
      if (pe) exp_q.push_back({((ones % 2) == 1) ^ pt, 1'b1});
      exp_q.push_back(2'b11);
   endfunction

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         exp_q.delete();
         cur_tx   <= 1'b1;
         cur_busy <= 1'b0;
      end else if (exp_q.size() != 0) begin
         {cur_tx, cur_busy} <= exp_q.pop_front();
      end else if (!cur_busy && DATA_VALID) begin
         cur_tx   <= 1'b0;
         cur_busy <= 1'b1;
         push_rest_of_frame(P_DATA, PAR_EN, PAR_TYP);
      end else begin
         cur_tx   <= 1'b1;
         cur_busy <= 1'b0;
      end
   end

   always @(negedge CLK) begin
      if (check_en) begin
         total++;
         if (TX_OUT !== cur_tx || BUSY !== cur_busy) begin
            bad++;
            $display("FAIL model t=%0t: tx=%b busy=%b expected tx=%b busy=%b",
                     $time, TX_OUT, BUSY, cur_tx, cur_busy);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Strobe one frame, optionally change inputs at sample index chg_at, record n samples
   task automatic frame_capture(input logic [7:0] d, input logic pe, input logic pt,
                                input int chg_at, input logic [7:0] d2, input logic pe2,
                                input logic pt2, input int n,
                                output logic [15:0] bits, output int bcnt);
      @(negedge CLK);
      P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
      bits = 16'h0000;
      bcnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         DATA_VALID = 1'b0;
         bits[i] = TX_OUT;
         if (BUSY) bcnt++;
         if (i == chg_at) begin
            P_DATA = d2; PAR_EN = pe2; PAR_TYP = pt2;
         end
      end
   endtask

   logic [15:0] bits;
   int          bcnt;
   logic        busy_arr[32];
   int          r1, r2, gap, nbusy;

   initial begin
      total = 0; bad = 0; check_en = 1'b0;
      RST = 1'b1; DATA_VALID = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      #1;
      RST = 1'b0; DATA_VALID = 1'b1; P_DATA = 8'hA5;
      check_en = 1'b1;

      // Reset held with a strobe present: line idle throughout
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("reset_tx", int'(TX_OUT), 1);
         chk("reset_busy", int'(BUSY), 0);
      end
      DATA_VALID = 1'b0;
      RST = 1'b1;
      nbusy = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         if (BUSY || !TX_OUT) nbusy++;
      end
      chk("no_frame_after_release", nbusy, 0);

      // 0xA5 without parity
      frame_capture(8'hA5, 1'b0, 1'b0, -1, 8'h00, 1'b0, 1'b0, 14, bits, bcnt);
      chk("a5_noparity_bits", int'(bits[13:0]), int'(14'b11111101001010));
      chk("a5_noparity_busy", bcnt, 10);

      // Parity values and frame length with parity
      frame_capture(8'hA5, 1'b1, 1'b0, -1, 8'h00, 1'b0, 1'b0, 14, bits, bcnt);
      chk("a5_even_par", int'(bits[9]), 0);
      chk("a5_even_stop", int'(bits[10]), 1);
      chk("a5_even_busy", bcnt, 11);
      frame_capture(8'hA5, 1'b1, 1'b1, -1, 8'h00, 1'b0, 1'b0, 14, bits, bcnt);
      chk("a5_odd_par", int'(bits[9]), 1);
      frame_capture(8'h01, 1'b1, 1'b0, -1, 8'h00, 1'b0, 1'b0, 14, bits, bcnt);
      chk("01_even_par", int'(bits[9]), 1);
      frame_capture(8'h01, 1'b1, 1'b1, -1, 8'h00, 1'b0, 1'b0, 14, bits, bcnt);
      chk("01_odd_par", int'(bits[9]), 0);
      chk("01_odd_busy", bcnt, 11);

      // Inputs changed at data bit 2 leave the frame untouched
      frame_capture(8'h0F, 1'b1, 1'b0, 3, 8'hF0, 1'b0, 1'b1, 14, bits, bcnt);
      chk("midframe_bits", int'(bits[10:0]), int'(11'b10000011110));
      chk("midframe_busy", bcnt, 11);

      // DATA_VALID held high: back-to-back frames
      @(negedge CLK);
      P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         busy_arr[i] = BUSY;
         if (i == 0) P_DATA = 8'hFF;
      end
      DATA_VALID = 1'b0;
      r1 = -1; r2 = -1;
      for (int i = 0; i < 30; i++) begin
         if (busy_arr[i] && (i == 0 || !busy_arr[i-1])) begin
            if (r1 < 0) r1 = i;
            else if (r2 < 0) r2 = i;
         end
      end
      gap = 0;
      for (int i = 0; i < 30; i++) if (i > r1 && i < r2 && !busy_arr[i]) gap++;
      chk("b2b_first_start", r1, 0);
      chk("b2b_period", r2 - r1, 11);
      chk("b2b_idle_gap", gap, 1);
      repeat (12) @(negedge CLK);
      nbusy = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         if (BUSY) nbusy++;
      end
      chk("no_queued_strobe", nbusy, 0);

      // Reset pulse at data bit 4 of a 0x3C frame
      @(negedge CLK);
      P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
      @(negedge CLK);
      DATA_VALID = 1'b0;
      repeat (5) @(negedge CLK);
      chk("pre_reset_busy", int'(BUSY), 1);
      #1;
      RST = 1'b0;
      #1;
      chk("abort_tx", int'(TX_OUT), 1);
      chk("abort_busy", int'(BUSY), 0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      nbusy = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (BUSY || !TX_OUT) nbusy++;
      end
      chk("idle_after_abort", nbusy, 0);
      frame_capture(8'h3C, 1'b0, 1'b0, -1, 8'h00, 1'b0, 1'b0, 14, bits, bcnt);
      chk("post_reset_bits", int'(bits[9:0]), int'(10'b1001111000));
      chk("post_reset_busy", bcnt, 10);

      // Randomized strobes, data and options, including strobes while busy
      for (int i = 0; i < 800; i++) begin
         @(negedge CLK);
         DATA_VALID = ($urandom_range(0, 3) == 0);
         P_DATA     = 8'($urandom_range(0, 255));
         PAR_EN     = 1'($urandom_range(0, 1));
         PAR_TYP    = 1'($urandom_range(0, 1));
      end
      DATA_VALID = 1'b0;
      repeat (15) @(negedge CLK);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: accepts a parallel byte with a one-cycle valid strobe and serialises it on a single line as one frame. Frame order: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit. It runs on the TX clock domain with one bit per CLK cycle; baud generation is done upstream. It is the transmit-side counterpart of the RX path (sampler, parity/start/stop checkers) and drives the serial line into the link.

## Interface

Parameters:
- DATA_WIDTH, 8, width of the parallel data word.

Ports:
- CLK  input  1  TX clock; one serial bit per cycle.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel data, sampled when accepted.
- DATA_VALID  input  1  strobe requesting transmission of P_DATA.
- PAR_EN  input  1  parity bit inserted when 1, sampled with P_DATA.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled with P_DATA.
- TX_OUT  output  1  serial line; idle level 1; registered.
- BUSY  output  1  high while a frame is in progress; registered.

## Operation

- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT = 1, BUSY = 0.
  - DATA_VALID = 1 at a CLK edge latches P_DATA, PAR_EN and PAR_TYP into internal registers, then goes to START.
- START: TX_OUT = 0, BUSY = 1, next state DATA.
- DATA:
  - TX_OUT = latched_data[bit_cnt]; bit_cnt counts 0..DATA_WIDTH-1.
  - On the last bit, go to PARITY if latched PAR_EN = 1, else STOP.
- PARITY:
  - TX_OUT = ^latched_data XOR latched PAR_TYP.
  - Even parity makes the total count of 1s in data+parity even; odd parity makes it odd.
  - Next state STOP.
- STOP: TX_OUT = 1, next state IDLE unconditionally.
- DATA_VALID outside IDLE is ignored, not queued. P_DATA, PAR_EN and PAR_TYP changing mid-frame have no effect on the current frame.
- bit_cnt width is clog2(DATA_WIDTH). It resets to 0 on every entry into DATA and never wraps mid-frame.
- Reset values: TX_OUT = 1, BUSY = 0, state IDLE, bit_cnt 0, latched registers 0.
- Reset asserted mid-frame aborts the frame immediately and asynchronously: TX_OUT goes to 1 and BUSY to 0. No partial frame resumes after reset release.

## Timing

- The accepting edge is edge n; edge k is the k-th CLK edge after it.
- Edge n: START; TX_OUT = 0, BUSY = 1.
- Edges n+1 .. n+DATA_WIDTH: data bits 0..DATA_WIDTH-1.
- Edge n+DATA_WIDTH+1: parity bit if enabled, otherwise the stop bit.
- Stop bit occupies one cycle; the following edge returns to IDLE with BUSY = 0.
- BUSY is high for exactly DATA_WIDTH+2 cycles (no parity) or DATA_WIDTH+3 cycles (parity): 10 or 11 for DATA_WIDTH = 8.
- Minimum inter-frame gap: one IDLE cycle at TX_OUT = 1 after the stop bit. DATA_VALID held high continuously therefore yields frames every 11 cycles (no parity) or 12 cycles (parity).
- Latency from DATA_VALID sample to the start bit on TX_OUT: one edge.

## Structure

- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP, 3-bit encoding);
  - constants START_BIT = 0, STOP_BIT = 1, IDLE_LEVEL = 1;
  - parity type encoding PAR_EVEN = 0, PAR_ODD = 1.
- These are the same constants the RX checkers use.
- One natural sub-module, uart_tx_serializer:
  - holds the latched data register and bit_cnt;
  - inputs: load, shift_en; outputs: ser_bit, ser_done (last bit).
- The FSM, parity computation and output mux/register stay in uart_tx.

## Test plan

- Reset: RST low with DATA_VALID = 1 -> TX_OUT = 1, BUSY = 0 throughout; no frame after release until a new strobe.
- P_DATA = 0xA5, PAR_EN = 0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); BUSY high exactly 10 cycles.
- P_DATA = 0xA5, PAR_EN = 1: PAR_TYP = 0 gives parity bit 0, PAR_TYP = 1 gives parity bit 1. P_DATA = 0x01 gives 1 (even) / 0 (odd). BUSY high exactly 11 cycles.
- DATA_VALID held high with P_DATA = 0x55 then 0xFF, no parity -> two frames, start bits 11 cycles apart, exactly one idle-high cycle between them. Strobes during BUSY are not queued.
- P_DATA/PAR_EN changed mid-frame (0x0F -> 0xF0 at data bit 2) -> transmitted bits remain those of 0x0F with the originally sampled parity setting.
- RST pulsed low at data bit 4 of a 0x3C frame -> TX_OUT = 1 and BUSY = 0 immediately. After release the line stays idle until the next DATA_VALID, which then produces a complete, correct frame.
